// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
// State encoding and the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..N without wrapping inside one operation.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_ripple_sub.sv
// ripple_sub: combinational ripple-borrow subtractor, d = a - b.
// Ports: a, b (W bits) in; d (W bits), borrow_out (MSB cell borrow) out.
module ripple_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         borrow_out
);

    logic [W:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign d[i]    = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow_out = bw[W];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: N-cycle unsigned restoring divider with start/done handshake.
// Ports: clock, resetn, start, dividend, divisor in; busy, done, quotient,
// remainder, div_by_zero out (results held until the next accepted start).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state;
    state_t state_next;

    logic [N:0]    a;
    logic [N-1:0]  q;
    logic [N-1:0]  m;
    logic [CW-1:0] count;

    logic [N:0]   shifted;
    logic [N:0]   trial;
    logic         borrow;
    logic [N:0]   a_next;
    logic [N-1:0] q_next;

    // A stays below M, so A[N] is always 0 before the shift.
    assign shifted = {a[N-1:0], q[N-1]};

    ripple_sub #(
        .W(N + 1)
    ) u_sub (
        .a         (shifted),
        .b         ({1'b0, m}),
        .d         (trial),
        .borrow_out(borrow)
    );

    assign a_next = borrow ? shifted : trial;
    assign q_next = {q[N-2:0], ~borrow};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_next = (count == LAST) ? DONE : RUN;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        q     <= dividend;
                        m     <= divisor;
                        count <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a     <= a_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= q_next;
                        remainder   <= a_next[N-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): latency, handshake,
// divide-by-zero, async reset and an exhaustive operand sweep.
module tb_seq_divider;

    localparam int N = 4;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(
        .N(N)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issue one op at the next negedge, wait for done, check everything.
    task automatic run_op(input int dvd, input int dvs,
                          input int eq, input int er, input int ez);
        int cycles;
        int bcnt;
        int lat;
        @(negedge clock);
        dividend = dvd[N-1:0];
        divisor  = dvs[N-1:0];
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cycles = 0;
        bcnt   = 0;
        while (!done && cycles < 40) begin
            if (busy) bcnt++;
            @(negedge clock);
            cycles++;
        end
        lat = (ez != 0) ? 0 : N;
        chk($sformatf("lat %0d/%0d", dvd, dvs), cycles, lat);
        chk($sformatf("busy_cyc %0d/%0d", dvd, dvs), bcnt, lat);
        chk($sformatf("busy_at_done %0d/%0d", dvd, dvs), int'(busy), 0);
        chk($sformatf("q %0d/%0d", dvd, dvs), int'(quotient), eq);
        chk($sformatf("r %0d/%0d", dvd, dvs), int'(remainder), er);
        chk($sformatf("z %0d/%0d", dvd, dvs), int'(div_by_zero), ez);
    endtask

    initial begin
        int cycles;
        int dcnt;
        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_z", int'(div_by_zero), 0);
        @(negedge clock);
        resetn = 1'b1;

        run_op(13, 3, 4, 1, 0);
        run_op(15, 1, 15, 0, 0);
        run_op(7, 9, 0, 7, 0);
        run_op(0, 5, 0, 0, 0);
        run_op(9, 0, 15, 9, 1);
        run_op(15, 15, 1, 0, 0);
        run_op(14, 4, 3, 2, 0);

        // Starts during RUN and DONE must be ignored.
        @(negedge clock);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        dividend = 4'd5;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        chk("ign_lat", cycles, N - 2);
        chk("ign_q_run", int'(quotient), 4);
        chk("ign_r_run", int'(remainder), 1);
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("ign_busy", int'(busy), 0);
        chk("ign_done", int'(done), 0);
        chk("ign_q_done", int'(quotient), 4);
        chk("ign_r_done", int'(remainder), 1);
        run_op(11, 2, 5, 1, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge clock);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_q", int'(quotient), 0);
        chk("arst_r", int'(remainder), 0);
        chk("arst_z", int'(div_by_zero), 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        dcnt   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);
        run_op(6, 4, 1, 2, 0);

        // Exhaustive sweep at minimum start spacing.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                if (y == 0) run_op(x, y, 15, x, 1);
                else        run_op(x, y, x / y, x % y, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
